// File: rtl/vend_change_pkg.sv
// Shared definitions for the parametrised coin acceptor: coin codes, unit values, FSM states.
package vend_change_pkg;

  // Coin codes as sampled from the coin mechanism
  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  // Coin values in nickel units
  localparam int unsigned UNIT_NICKEL  = 1;
  localparam int unsigned UNIT_DIME    = 2;
  localparam int unsigned UNIT_QUARTER = 5;

  // Controller states
  typedef enum logic [1:0] {
    ST_ACCUM  = 2'b00,
    ST_VEND   = 2'b01,
    ST_CHANGE = 2'b10
  } state_e;

endpackage

// File: rtl/vend_change.sv
// Coin acceptor with programmable price: accumulates credit, vends, then pays change
// largest coin first, one coin per cycle. Rejects coins it cannot take.
module vend_change
  import vend_change_pkg::*;
#(
  parameter int unsigned PRICE    = 3,
  parameter int unsigned CREDIT_W = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                sold_out,
  output logic                dispense,
  output logic                change_dime,
  output logic                change_nickel,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  // The price range keeps credit + largest coin inside the credit register
  if (PRICE < 1 || PRICE > (2 ** CREDIT_W) - 5) begin : g_bad_price
    $error("vend_change: PRICE %0d outside 1..%0d", PRICE, (2 ** CREDIT_W) - 5);
  end

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic                reject_q;
  logic [SUM_W-1:0]    sum_d;
  logic                coin_vld;

  // Coin code to value in nickel units
  function automatic logic [2:0] coin_value(input logic [1:0] c);
    case (c)
      COIN_NICKEL:  return 3'(UNIT_NICKEL);
      COIN_DIME:    return 3'(UNIT_DIME);
      COIN_QUARTER: return 3'(UNIT_QUARTER);
      default:      return 3'd0;
    endcase
  endfunction

  // Credit plus the sampled coin, one bit wider than the credit register
  always_comb begin
    coin_vld = (coin != COIN_NONE);
    sum_d    = {1'b0, credit_q} + SUM_W'(coin_value(coin));
  end

  // Controller: state, credit and the registered reject pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_ACCUM;
      credit_q <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (cancel) begin
            reject_q <= coin_vld;
            if (credit_q != '0) state_q <= ST_CHANGE;
          end else if (coin_vld && sold_out) begin
            reject_q <= 1'b1;
          end else if (coin_vld) begin
            if (sum_d >= SUM_W'(PRICE)) begin
              state_q  <= ST_VEND;
              credit_q <= CREDIT_W'(sum_d - SUM_W'(PRICE));
            end else begin
              credit_q <= CREDIT_W'(sum_d);
            end
          end
        end
        ST_VEND: begin
          reject_q <= coin_vld;
          state_q  <= (credit_q != '0) ? ST_CHANGE : ST_ACCUM;
        end
        ST_CHANGE: begin
          reject_q <= coin_vld;
          if (credit_q >= CREDIT_W'(2)) begin
            credit_q <= credit_q - CREDIT_W'(2);
            if (credit_q == CREDIT_W'(2)) state_q <= ST_ACCUM;
          end else begin
            credit_q <= '0;
            state_q  <= ST_ACCUM;
          end
        end
        default: begin
          state_q  <= ST_ACCUM;
          credit_q <= '0;
        end
      endcase
    end
  end

  // Moore decodes of the state and credit registers
  always_comb begin
    dispense      = (state_q == ST_VEND);
    change_dime   = (state_q == ST_CHANGE) && (credit_q >= CREDIT_W'(2));
    change_nickel = (state_q == ST_CHANGE) && (credit_q == CREDIT_W'(1));
    busy          = (state_q != ST_ACCUM);
    credit        = credit_q;
    coin_reject   = reject_q;
  end

endmodule

// File: tb/tb_vend_change.sv
// Directed bench for vend_change at two price configurations.
module tb_vend_change;

  logic       clock;
  logic       reset;
  logic [1:0] coin_a, coin_b;
  logic       cancel_a, cancel_b;
  logic       sold_a, sold_b;
  logic       disp_a, dime_a, nick_a, rej_a, busy_a;
  logic       disp_b, dime_b, nick_b, rej_b, busy_b;
  logic [3:0] credit_a;
  logic [4:0] credit_b;

  int total = 0;
  int bad   = 0;

  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] Q = 2'b11;

  vend_change #(.PRICE(3), .CREDIT_W(4)) u_dut_a (
    .clock(clock), .reset(reset), .coin(coin_a), .cancel(cancel_a), .sold_out(sold_a),
    .dispense(disp_a), .change_dime(dime_a), .change_nickel(nick_a),
    .coin_reject(rej_a), .credit(credit_a), .busy(busy_a)
  );

  vend_change #(.PRICE(7), .CREDIT_W(5)) u_dut_b (
    .clock(clock), .reset(reset), .coin(coin_b), .cancel(cancel_b), .sold_out(sold_b),
    .dispense(disp_b), .change_dime(dime_b), .change_nickel(nick_b),
    .coin_reject(rej_b), .credit(credit_b), .busy(busy_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs to DUT A for one edge, then sample 1 time unit later
  task automatic tick_a(input logic [1:0] c, input logic cn, input logic so);
    coin_a = c; cancel_a = cn; sold_a = so;
    @(posedge clock); #1;
    coin_a = 2'b00; cancel_a = 1'b0; sold_a = 1'b0;
  endtask

  task automatic tick_b(input logic [1:0] c);
    coin_b = c;
    @(posedge clock); #1;
    coin_b = 2'b00;
  endtask

  task automatic exp_a(input string tag, input int d, input int dm, input int nk,
                       input int rj, input int cr, input int bz);
    chk({tag, ".disp"},   int'(disp_a),   d);
    chk({tag, ".dime"},   int'(dime_a),   dm);
    chk({tag, ".nick"},   int'(nick_a),   nk);
    chk({tag, ".rej"},    int'(rej_a),    rj);
    chk({tag, ".credit"}, int'(credit_a), cr);
    chk({tag, ".busy"},   int'(busy_a),   bz);
  endtask

  task automatic exp_b(input string tag, input int d, input int dm, input int nk,
                       input int rj, input int cr, input int bz);
    chk({tag, ".disp"},   int'(disp_b),   d);
    chk({tag, ".dime"},   int'(dime_b),   dm);
    chk({tag, ".nick"},   int'(nick_b),   nk);
    chk({tag, ".rej"},    int'(rej_b),    rj);
    chk({tag, ".credit"}, int'(credit_b), cr);
    chk({tag, ".busy"},   int'(busy_b),   bz);
  endtask

  initial begin
    reset = 1'b1;
    coin_a = 2'b00; cancel_a = 1'b0; sold_a = 1'b0;
    coin_b = 2'b00; cancel_b = 1'b0; sold_b = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    exp_a("rst_a", 0, 0, 0, 0, 0, 0);
    exp_b("rst_b", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Three nickels: exact price, no change
    tick_a(N, 0, 0); exp_a("n3.1", 0, 0, 0, 0, 1, 0);
    tick_a(N, 0, 0); exp_a("n3.2", 0, 0, 0, 0, 2, 0);
    tick_a(N, 0, 0); exp_a("n3.v", 1, 0, 0, 0, 0, 1);
    tick_a(0, 0, 0); exp_a("n3.i", 0, 0, 0, 0, 0, 0);

    // Quarter: vend then one dime
    tick_a(Q, 0, 0); exp_a("q.v",  1, 0, 0, 0, 2, 1);
    tick_a(0, 0, 0); exp_a("q.c1", 0, 1, 0, 0, 2, 1);
    tick_a(0, 0, 0); exp_a("q.i",  0, 0, 0, 0, 0, 0);

    // Dime then quarter: credit 4 after vend, two dimes
    tick_a(D, 0, 0); exp_a("dq.1",  0, 0, 0, 0, 2, 0);
    tick_a(Q, 0, 0); exp_a("dq.v",  1, 0, 0, 0, 4, 1);
    tick_a(0, 0, 0); exp_a("dq.c1", 0, 1, 0, 0, 4, 1);
    tick_a(0, 0, 0); exp_a("dq.c2", 0, 1, 0, 0, 2, 1);
    tick_a(0, 0, 0); exp_a("dq.i",  0, 0, 0, 0, 0, 0);

    // Nickel then dime: exact price
    tick_a(N, 0, 0); exp_a("nd.1", 0, 0, 0, 0, 1, 0);
    tick_a(D, 0, 0); exp_a("nd.v", 1, 0, 0, 0, 0, 1);
    tick_a(0, 0, 0); exp_a("nd.i", 0, 0, 0, 0, 0, 0);

    // Nickel then cancel: one nickel back
    tick_a(N, 0, 0); exp_a("nc.1", 0, 0, 0, 0, 1, 0);
    tick_a(0, 1, 0); exp_a("nc.c", 0, 0, 1, 0, 1, 1);
    tick_a(0, 0, 0); exp_a("nc.i", 0, 0, 0, 0, 0, 0);

    // Dime with cancel at credit 1: coin rejected, nickel refunded
    tick_a(N, 0, 0); exp_a("dc.1", 0, 0, 0, 0, 1, 0);
    tick_a(D, 1, 0); exp_a("dc.c", 0, 0, 1, 1, 1, 1);
    tick_a(0, 0, 0); exp_a("dc.i", 0, 0, 0, 0, 0, 0);

    // Cancel at zero credit with a coin: reject, stay idle
    tick_a(N, 1, 0); exp_a("c0.r", 0, 0, 0, 1, 0, 0);
    tick_a(0, 0, 0); exp_a("c0.i", 0, 0, 0, 0, 0, 0);

    // Sold out: quarter rejected
    tick_a(Q, 0, 1); exp_a("so.r", 0, 0, 0, 1, 0, 0);
    tick_a(0, 0, 0); exp_a("so.i", 0, 0, 0, 0, 0, 0);

    // Coin during VEND and CHANGE: rejected, change sequence intact
    tick_a(D, 0, 0); exp_a("cc.1",  0, 0, 0, 0, 2, 0);
    tick_a(Q, 0, 0); exp_a("cc.v",  1, 0, 0, 0, 4, 1);
    tick_a(D, 0, 0); exp_a("cc.c1", 0, 1, 0, 1, 4, 1);
    tick_a(N, 0, 0); exp_a("cc.c2", 0, 1, 0, 1, 2, 1);
    tick_a(0, 0, 0); exp_a("cc.i",  0, 0, 0, 0, 0, 0);

    // Reset while in VEND discards change
    tick_a(Q, 0, 0); exp_a("rv.v", 1, 0, 0, 0, 2, 1);
    reset = 1'b1;
    tick_a(0, 0, 0); exp_a("rv.r", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick_a(0, 0, 0); exp_a("rv.i", 0, 0, 0, 0, 0, 0);

    // PRICE=7: quarter + dime is exact
    tick_b(Q); exp_b("b.qd1", 0, 0, 0, 0, 5, 0);
    tick_b(D); exp_b("b.qdv", 1, 0, 0, 0, 0, 1);
    tick_b(0); exp_b("b.qdi", 0, 0, 0, 0, 0, 0);

    // PRICE=7: two quarters vend with credit 3; third quarter rejected in VEND
    tick_b(Q); exp_b("b.qq1", 0, 0, 0, 0, 5, 0);
    tick_b(Q); exp_b("b.qqv", 1, 0, 0, 0, 3, 1);
    tick_b(Q); exp_b("b.qc1", 0, 1, 0, 1, 3, 1);
    tick_b(0); exp_b("b.qc2", 0, 0, 1, 0, 1, 1);
    tick_b(0); exp_b("b.qqi", 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
